// File: rtl/vga_timing_pattern_gen.sv
// VGA timing generator with test-pattern engine; pixel rate set by an internal clock-enable divider.
// All outputs registered together, one clk after the divider terminal count; free-running, no backpressure.
module vga_timing_pattern_gen #(
    parameter int PIX_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 11,
    parameter int COLOR_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             mode,
    input  logic [3*COLOR_W-1:0]   fg_color,
    output logic                   pix_ce,
    output logic [CNT_W-1:0]       pix_x,
    output logic [CNT_W-1:0]       pix_y,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   hblank,
    output logic                   vblank,
    output logic                   de,
    output logic                   line_start,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     vga_r,
    output logic [COLOR_W-1:0]     vga_g,
    output logic [COLOR_W-1:0]     vga_b
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
    localparam cnt_t HA       = cnt_t'(H_ACTIVE);
    localparam cnt_t VA       = cnt_t'(V_ACTIVE);
    localparam cnt_t HA_LAST  = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t VA_LAST  = cnt_t'(V_ACTIVE - 1);
    localparam cnt_t HS_BEG   = cnt_t'(H_ACTIVE + H_FP);
    localparam cnt_t HS_END   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam cnt_t VS_BEG   = cnt_t'(V_ACTIVE + V_FP);
    localparam cnt_t VS_END   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0]     div_q, div_d;
    logic                 ce_q, ce_d;
    cnt_t                 x_q, x_d, y_q, y_d;
    logic                 hs_q, hs_d, vs_q, vs_d;
    logic                 hb_q, hb_d, vb_q, vb_d, de_q, de_d;
    logic                 ls_q, ls_d, fs_q, fs_d;
    logic [COLOR_W-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic [1:0]           mode_q, mode_d;
    logic [3*COLOR_W-1:0] fg_q, fg_d;
    logic [2:0]           bar;

    // Position advance and once-per-frame pattern latch.
    always_comb begin
        ce_d  = (div_q == DIV_LAST);
        div_d = ce_d ? '0 : div_q + DIV_W'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (ce_d) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + cnt_t'(1);
            end else begin
                x_d = x_q + cnt_t'(1);
            end
        end
        ls_d   = ce_d && (x_d == '0);
        fs_d   = ls_d && (y_d == '0);
        mode_d = fs_d ? mode : mode_q;
        fg_d   = fs_d ? fg_color : fg_q;
    end

    // Everything below is a function of the next position, so all outputs stay aligned.
    always_comb begin
        hb_d = (x_d >= HA);
        vb_d = (y_d >= VA);
        de_d = !hb_d && !vb_d;
        hs_d = ((x_d >= HS_BEG) && (x_d < HS_END)) ? HS_POL : !HS_POL;
        vs_d = ((y_d >= VS_BEG) && (y_d < VS_END)) ? VS_POL : !VS_POL;
        bar  = '0;
        for (int k = 1; k < 8; k++) begin
            if ({x_d, 3'b000} >= (CNT_W+3)'(k * H_ACTIVE)) bar = 3'(k);
        end
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (de_d) begin
            case (mode_d)
                2'd0: {r_d, g_d, b_d} = fg_d;
                2'd1: begin
                    r_d = {COLOR_W{~bar[1]}};
                    g_d = {COLOR_W{~bar[2]}};
                    b_d = {COLOR_W{~bar[0]}};
                end
                2'd2: if (x_d[5] ^ y_d[5]) {r_d, g_d, b_d} = fg_d;
                default: begin
                    if ((x_d[5:0] == 6'd0) || (y_d[5:0] == 6'd0) ||
                        (x_d == HA_LAST) || (y_d == VA_LAST)) begin
                        r_d = '1;
                        g_d = '1;
                        b_d = '1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            ce_q   <= 1'b0;
            x_q    <= H_LAST;
            y_q    <= V_LAST;
            hs_q   <= !HS_POL;
            vs_q   <= !VS_POL;
            hb_q   <= 1'b1;
            vb_q   <= 1'b1;
            de_q   <= 1'b0;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            mode_q <= 2'd0;
            fg_q   <= '1;
        end else begin
            div_q  <= div_d;
            ce_q   <= ce_d;
            x_q    <= x_d;
            y_q    <= y_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            hb_q   <= hb_d;
            vb_q   <= vb_d;
            de_q   <= de_d;
            ls_q   <= ls_d;
            fs_q   <= fs_d;
            r_q    <= r_d;
            g_q    <= g_d;
            b_q    <= b_d;
            mode_q <= mode_d;
            fg_q   <= fg_d;
        end
    end

    assign pix_ce      = ce_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign hblank      = hb_q;
    assign vblank      = vb_q;
    assign de          = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;

endmodule
